// File: rtl/alu_accumulator_pkg.sv
// Shared types for the execute-stage accumulator: operation codes and control states.
package alu_accumulator_pkg;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_LOAD,
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_INC,
    ALU_CLR,
    ALU_SHL
  } alu_op_t;

  typedef enum logic {
    ALU_IDLE,
    ALU_MUL_BUSY
  } alu_state_t;

  localparam int ALU_WIDTH_DEF = 12;

endpackage

// File: rtl/alu_accumulator_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// finish is high during the step whose edge brings the counter to WIDTH.
module shift_add_multiplier #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 finish,
  output logic [2*WIDTH-1:0]   product_n
);

  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] prod_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic               busy_p0;

  // product value that the current step writes; the top captures it on finish
  always_comb begin
    product_n = prod_p0;
    if (mplier_p0[0]) begin
      product_n = prod_p0 + mcand_p0;
    end
  end

  assign finish = busy_p0 && (cnt_p0 == CNT_W'(WIDTH - 1));
  assign busy   = busy_p0;

  // ---- step register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
      prod_p0 <= '0;
    end else if (start) begin
      busy_p0   <= 1'b1;
      cnt_p0    <= '0;
      prod_p0   <= '0;
      mcand_p0  <= {{WIDTH{1'b0}}, multiplicand};
      mplier_p0 <= multiplier;
    end else if (busy_p0) begin
      prod_p0   <= product_n;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + CNT_W'(1);
      if (finish) begin
        busy_p0 <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// Execute stage owning the accumulator AC, its zero/carry flags and a done strobe.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiply; otherwise ALU_MUL acts as NOP.
module alu_accumulator
  import alu_accumulator_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  alu_op_t          alu_op,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [WIDTH-1:0] ac_out,
  output logic             z_flag,
  output logic             c_flag,
  output logic             done
);

  function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // bit WIDTH of the difference is the unsigned borrow (b > a)
  function automatic logic [WIDTH:0] sub_b(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  alu_state_t       state_p1, state_n;
  logic [WIDTH-1:0] ac_p1, ac_n;
  logic             c_p1, c_n;
  logic             z_p1;
  logic             vld_p1, vld_n;

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_busy;
  logic               mul_finish;
  logic [2*WIDTH-1:0] mul_product_n;

  shift_add_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (ac_p1),
    .multiplier   (bus_in),
    .busy         (mul_busy),
    .finish       (mul_finish),
    .product_n    (mul_product_n)
  );
`endif

  always_comb begin
    state_n = state_p1;
    ac_n    = ac_p1;
    c_n     = c_p1;
    vld_n   = 1'b0;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_p1)
      ALU_IDLE: begin
        if (op_valid) begin
          vld_n = 1'b1;
          case (alu_op)
            ALU_LOAD: begin
              ac_n = bus_in;
              c_n  = 1'b0;
            end
            ALU_CLR: begin
              ac_n = '0;
              c_n  = 1'b0;
            end
            ALU_ADD: {c_n, ac_n} = add_c(ac_p1, bus_in);
            ALU_SUB: {c_n, ac_n} = sub_b(ac_p1, bus_in);
            ALU_INC: {c_n, ac_n} = add_c(ac_p1, WIDTH'(1));
            ALU_SHL: {c_n, ac_n} = {ac_p1, 1'b0};
            ALU_MUL: begin
`ifdef ALU_MUL_EN
              // result appears only when the multiplier finishes
              mul_start = 1'b1;
              vld_n     = 1'b0;
              state_n   = ALU_MUL_BUSY;
`endif
            end
            default: ;
          endcase
        end
      end
      ALU_MUL_BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_finish) begin
          ac_n    = mul_product_n[WIDTH-1:0];
          c_n     = |mul_product_n[2*WIDTH-1:WIDTH];
          vld_n   = 1'b1;
          state_n = ALU_IDLE;
        end else if (!mul_busy) begin
          state_n = ALU_IDLE;
        end
`else
        state_n = ALU_IDLE;
`endif
      end
      default: state_n = ALU_IDLE;
    endcase
  end

  // ---- accumulator / flag register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ALU_IDLE;
      ac_p1    <= '0;
      c_p1     <= 1'b0;
      z_p1     <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      state_p1 <= state_n;
      ac_p1    <= ac_n;
      c_p1     <= c_n;
      z_p1     <= (ac_n == '0);
      vld_p1   <= vld_n;
    end
  end

  assign op_ready = (state_p1 == ALU_IDLE);
  assign ac_out   = ac_p1;
  assign z_flag   = z_p1;
  assign c_flag   = c_p1;
  assign done     = vld_p1;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: directed plan plus randomized ops against an arithmetic model.
module tb_alu_accumulator;
  import alu_accumulator_pkg::*;

  localparam int W   = 12;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] bus_in = '0;
  alu_op_t      alu_op = ALU_NOP;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] ac_out;
  logic         z_flag;
  logic         c_flag;
  logic         done;

  int checks = 0;
  int failures = 0;
  int m_ac = 0;
  int m_c = 0;

  alu_accumulator #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .alu_op   (alu_op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .ac_out   (ac_out),
    .z_flag   (z_flag),
    .c_flag   (c_flag),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int exp_done);
    chk({tag, ".ac"}, 32'(ac_out), 32'(m_ac));
    chk({tag, ".z"}, 32'(z_flag), (m_ac == 0) ? 32'd1 : 32'd0);
    chk({tag, ".c"}, 32'(c_flag), 32'(m_c));
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".ready"}, 32'(op_ready), 32'd1);
  endtask

  function automatic void model_apply(input alu_op_t op, input int d);
    int s;
    case (op)
      ALU_LOAD: begin m_ac = d; m_c = 0; end
      ALU_CLR:  begin m_ac = 0; m_c = 0; end
      ALU_ADD:  begin s = m_ac + d; m_c = (s >= MOD) ? 1 : 0; m_ac = s % MOD; end
      ALU_SUB:  begin m_c = (d > m_ac) ? 1 : 0; m_ac = (m_ac - d + MOD) % MOD; end
      ALU_INC:  begin m_c = (m_ac == MOD - 1) ? 1 : 0; m_ac = (m_ac + 1) % MOD; end
      ALU_SHL:  begin m_c = (m_ac >= MOD / 2) ? 1 : 0; m_ac = (m_ac * 2) % MOD; end
      default: ;
    endcase
  endfunction

  // Single-cycle op issued at a negedge; result checked at the following negedge.
  task automatic single(input alu_op_t op, input logic [W-1:0] d, input string tag);
    alu_op   = op;
    bus_in   = d;
    op_valid = 1'b1;
    @(posedge clk);
    model_apply(op, int'(d));
    @(negedge clk);
    op_valid = 1'b0;
    chk_outputs(tag, 1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = '0;
      1: v = '1;
      2: v = 12'h800;
      3: v = 12'h7FF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

`ifdef ALU_MUL_EN
  task automatic mul(input logic [W-1:0] d, input int abort_k, input bit poke, input string tag);
    int lat;
    int prod;
    int dn_seen;
    bit rdy_ok;
    bit aborted;
    alu_op   = ALU_MUL;
    bus_in   = d;
    op_valid = 1'b1;
    @(posedge clk);
    prod = m_ac * int'(d);
    @(negedge clk);
    op_valid = 1'b0;
    bus_in   = W'($urandom);
    lat      = -1;
    aborted  = 1'b0;
    rdy_ok   = (op_ready === 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (poke && k == 5) begin
        op_valid = 1'b1;
        alu_op   = ALU_LOAD;
        bus_in   = 12'hABC;
      end
      if (poke && k == 6) op_valid = 1'b0;
      if (abort_k != 0 && k == abort_k) rst = 1'b1;
      @(negedge clk);
      if (abort_k != 0 && k == abort_k) begin
        rst     = 1'b0;
        aborted = 1'b1;
        m_ac    = 0;
        m_c     = 0;
        chk_outputs({tag, ".abort"}, 0);
        break;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (op_ready !== 1'b0) rdy_ok = 1'b0;
    end
    if (aborted) begin
      dn_seen = 0;
      for (int j = 0; j < 14; j++) begin
        @(negedge clk);
        if (done !== 1'b0) dn_seen++;
      end
      chk({tag, ".no_done_after_abort"}, 32'(dn_seen), 32'd0);
      chk({tag, ".ready_after_abort"}, 32'(op_ready), 32'd1);
    end else begin
      chk({tag, ".latency"}, 32'(lat), 32'd12);
      chk({tag, ".ready_low_while_busy"}, 32'(rdy_ok), 32'd1);
      m_ac = prod % MOD;
      m_c  = (prod >= MOD) ? 1 : 0;
      chk_outputs(tag, 1);
      @(negedge clk);
      chk({tag, ".done_single_pulse"}, 32'(done), 32'd0);
    end
  endtask
`endif

  initial begin
    alu_op_t op;
    logic [W-1:0] d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs("reset", 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done_low", 32'(done), 32'd0);

    single(ALU_LOAD, 12'h7FF, "load_7ff");
    single(ALU_ADD, 12'h801, "add_801");
    @(negedge clk);
    chk("idle_after_add", 32'(done), 32'd0);

    single(ALU_LOAD, 12'h005, "load_005");
    single(ALU_SUB, 12'h007, "sub_007");
    single(ALU_INC, 12'h000, "inc1");
    single(ALU_INC, 12'h000, "inc2");
    single(ALU_SHL, 12'h000, "shl_zero");
    single(ALU_LOAD, 12'h9A5, "load_9a5");
    single(ALU_SHL, 12'h000, "shl_msb");
    single(ALU_NOP, 12'h3C3, "nop");
    single(ALU_CLR, 12'hFFF, "clr");

`ifdef ALU_MUL_EN
    single(ALU_LOAD, 12'h010, "load_010");
    mul(12'h020, 0, 1'b1, "mul_10x20");
    single(ALU_LOAD, 12'h100, "load_100");
    mul(12'h100, 0, 1'b0, "mul_ovf");
    single(ALU_LOAD, 12'h100, "load_100b");
    mul(12'h100, 5, 1'b0, "mul_abort");
`else
    single(ALU_LOAD, 12'h123, "load_123");
    single(ALU_MUL, 12'h002, "mul_as_nop");
    @(negedge clk);
    chk("mul_as_nop.idle_done", 32'(done), 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      op = alu_op_t'($urandom_range(0, 7));
      d  = pick();
`ifdef ALU_MUL_EN
      if (op == ALU_MUL) mul(d, 0, 1'b0, "rnd_mul");
      else single(op, d, "rnd");
`else
      single(op, d, "rnd");
`endif
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("rnd_idle_done", 32'(done), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
